// File: rtl/canny_accel_udiv_seq_27ns_11ns_16_pkg.sv
`default_nettype none
// ============================================================================
//  Package : canny_accel_div_pkg
//  Purpose : Shared widths and FSM state encoding for the canny_accel
//            sequential unsigned divider (27-bit / 11-bit -> 16q + 11r).
//  Contents: QUOT_W, DIVISOR_W, DIVIDEND_W, state_t
//  Revision: 1.0 - initial release
// ============================================================================
package canny_accel_div_pkg;

  localparam int QUOT_W     = 16;
  localparam int DIVISOR_W  = 11;
  localparam int DIVIDEND_W = 27;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    CALC  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage : canny_accel_div_pkg
`default_nettype wire

// File: rtl/canny_accel_udiv_seq_27ns_11ns_16_if.sv
`default_nettype none
// ============================================================================
//  Interface : canny_accel_udiv_seq_27ns_11ns_16_if
//  Purpose   : Operand and result handshake bundle of the sequential divider.
//  Signals   : in_valid/in_ready/dividend/divisor   - operation request
//              out_valid/out_ready/quotient/remainder/div0/ovf - result
//  Modports  : master - upstream/downstream side (drives requests, accepts results)
//              slave  - divider side
//  Revision  : 1.0 - initial release
// ============================================================================
interface canny_accel_udiv_seq_27ns_11ns_16_if;
  import canny_accel_div_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [QUOT_W-1:0]     quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div0;
  logic                  ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div0, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div0, ovf
  );

endinterface : canny_accel_udiv_seq_27ns_11ns_16_if
`default_nettype wire

// File: rtl/canny_accel_udiv_seq_27ns_11ns_16_step.sv
`default_nettype none
// ============================================================================
//  Module  : canny_accel_udiv_step
//  Purpose : One combinational restoring-division iteration.
//  Ports   : prem_i    - partial remainder (always < divisor_i)
//            dbit_i    - next dividend bit, MSB first
//            divisor_i - divisor
//            prem_o    - updated partial remainder
//            qbit_o    - quotient bit produced by this iteration
//  Revision: 1.0 - initial release
// ============================================================================
module canny_accel_udiv_step #(
  parameter int DIVISOR_W = canny_accel_div_pkg::DIVISOR_W
) (
  input  logic [DIVISOR_W-1:0] prem_i,
  input  logic                 dbit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W-1:0] prem_o,
  output logic                 qbit_o
);

  logic [DIVISOR_W:0]   w_shift;
  logic [DIVISOR_W+1:0] w_trial;
  logic [DIVISOR_W:0]   w_sel;
  logic                 w_unused_msb;

  always_comb begin
    w_shift = {prem_i, dbit_i};
    // One extra bit above the trial width acts as the borrow/sign flag.
    w_trial = {1'b0, w_shift} - {2'b00, divisor_i};
    qbit_o  = ~w_trial[DIVISOR_W+1];
    w_sel   = qbit_o ? w_trial[DIVISOR_W:0] : w_shift;
    // Because prem_i < divisor_i the kept value is always < divisor_i,
    // so its top bit is zero and the remainder fits in DIVISOR_W bits.
    prem_o       = w_sel[DIVISOR_W-1:0];
    w_unused_msb = w_sel[DIVISOR_W];
  end

endmodule : canny_accel_udiv_step
`default_nettype wire

// File: rtl/canny_accel_udiv_seq_27ns_11ns_16.sv
`default_nettype none
// ============================================================================
//  Module  : canny_accel_udiv_seq_27ns_11ns_16
//  Purpose : Sequential unsigned radix-2 restoring divider, one quotient bit
//            per enabled cycle. 27-bit dividend / 11-bit divisor gives a
//            16-bit quotient and 11-bit remainder, with div0/ovf saturation.
//  Ports   : clk     - clock, rising edge
//            reset_n - asynchronous active-low reset
//            ce      - clock enable; 0 freezes all state and outputs
//            bus     - slave side of the request/result handshake bundle
//  Revision: 1.0 - initial release
// ============================================================================
module canny_accel_udiv_seq_27ns_11ns_16 #(
  parameter int QUOT_W     = canny_accel_div_pkg::QUOT_W,
  parameter int DIVISOR_W  = canny_accel_div_pkg::DIVISOR_W,
  parameter int DIVIDEND_W = canny_accel_div_pkg::DIVIDEND_W
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 ce,
  canny_accel_udiv_seq_27ns_11ns_16_if.slave   bus
);
  import canny_accel_div_pkg::*;

  localparam int CNT_W = $clog2(QUOT_W);

  generate
    if (DIVIDEND_W != QUOT_W + DIVISOR_W) begin : g_width_check
      $error("DIVIDEND_W must equal QUOT_W + DIVISOR_W");
    end
  endgenerate

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     count_q;
  logic [DIVISOR_W-1:0] dvd_hi_q;   // upper dividend bits, checked for overflow
  logic [QUOT_W-1:0]    dvd_lo_q;   // lower dividend bits; quotient bits shift in at LSB
  logic [DIVISOR_W-1:0] divisor_q;
  logic [DIVISOR_W-1:0] prem_q;
  logic [QUOT_W-1:0]    quot_q;
  logic [DIVISOR_W-1:0] rem_q;
  logic                 div0_q;
  logic                 ovf_q;

  logic [DIVISOR_W-1:0] w_prem_next;
  logic                 w_qbit;
  logic                 w_last;
  logic [QUOT_W-1:0]    w_quot_next;

  canny_accel_udiv_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .prem_i    (prem_q),
    .dbit_i    (dvd_lo_q[QUOT_W-1]),
    .divisor_i (divisor_q),
    .prem_o    (w_prem_next),
    .qbit_o    (w_qbit)
  );

  assign w_last      = (count_q == CNT_W'(QUOT_W - 1));
  assign w_quot_next = {dvd_lo_q[QUOT_W-2:0], w_qbit};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else if (ce) begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.in_valid) state_d = CHECK;
      CHECK: if ((divisor_q == '0) || (dvd_hi_q >= divisor_q)) state_d = DONE;
             else                                              state_d = CALC;
      CALC:  if (w_last) state_d = DONE;
      DONE:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.quotient  = quot_q;
    bus.remainder = rem_q;
    bus.div0      = div0_q;
    bus.ovf       = ovf_q;
  end

  // Datapath: operand capture, iteration, result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      dvd_hi_q  <= '0;
      dvd_lo_q  <= '0;
      divisor_q <= '0;
      prem_q    <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (ce) begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            dvd_hi_q  <= bus.dividend[DIVIDEND_W-1:QUOT_W];
            dvd_lo_q  <= bus.dividend[QUOT_W-1:0];
            divisor_q <= bus.divisor;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
          end
        end
        CHECK: begin
          if (divisor_q == '0) begin
            div0_q <= 1'b1;
            quot_q <= '1;
            rem_q  <= '0;
          end else if (dvd_hi_q >= divisor_q) begin
            // Upper bits >= divisor means the quotient needs > QUOT_W bits.
            ovf_q  <= 1'b1;
            quot_q <= '1;
            rem_q  <= '0;
          end else begin
            prem_q  <= dvd_hi_q;
            count_q <= '0;
          end
        end
        CALC: begin
          prem_q   <= w_prem_next;
          dvd_lo_q <= w_quot_next;
          count_q  <= count_q + CNT_W'(1);
          if (w_last) begin
            quot_q <= w_quot_next;
            rem_q  <= w_prem_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : canny_accel_udiv_seq_27ns_11ns_16
`default_nettype wire

// File: tb/tb_canny_accel_udiv_seq_27ns_11ns_16.sv
`default_nettype none
// ============================================================================
//  Module  : tb_canny_accel_udiv_seq_27ns_11ns_16
//  Purpose : Scoreboard testbench for the sequential divider: directed cases
//            plus randomized operations with ce and out_ready gaps.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_canny_accel_udiv_seq_27ns_11ns_16;

  logic clk;
  logic reset_n;
  logic ce;
  logic ce_dir, rand_ce;
  logic ordy_dir, rand_ordy;

  canny_accel_udiv_seq_27ns_11ns_16_if bus ();

  canny_accel_udiv_seq_27ns_11ns_16 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] q;
    logic [10:0] r;
    logic        d0;
    logic        ov;
    int          lat;
    int          acc_ce;
    int          acc_raw;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;
  int   edge_cnt;
  int   ce_edge_cnt;
  int   last_raw_lat;
  bit   in_result;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (ce) ce_edge_cnt <= ce_edge_cnt + 1;
  end

  // Enable and downstream-ready drivers, updated just after each edge
  always @(posedge clk) begin
    #1;
    ce            = rand_ce   ? ($urandom_range(0, 9) != 0) : ce_dir;
    bus.out_ready = rand_ordy ? ($urandom_range(0, 9) < 7)  : ordy_dir;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: plain integer division with the saturation rules
  function automatic exp_t model(input logic [26:0] a, input logic [10:0] b);
    exp_t e;
    longint unsigned qa;
    e = '{q: 16'd0, r: 11'd0, d0: 1'b0, ov: 1'b0, lat: 0, acc_ce: 0, acc_raw: 0};
    if (b == 0) begin
      e.d0 = 1'b1; e.q = 16'hFFFF; e.lat = 2;
    end else begin
      qa = longint'(a) / longint'(b);
      if (qa >= 65536) begin
        e.ov = 1'b1; e.q = 16'hFFFF; e.lat = 2;
      end else begin
        e.q = 16'(qa); e.r = 11'(longint'(a) % longint'(b)); e.lat = 18;
      end
    end
    return e;
  endfunction

  task automatic issue(input logic [26:0] a, input logic [10:0] b);
    int   n;
    bit   done;
    exp_t e;
    n = 0; done = 0;
    @(posedge clk); #1;
    bus.dividend = a; bus.divisor = b; bus.in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (ce && bus.in_ready) begin
        e = model(a, b);
        e.acc_ce  = ce_edge_cnt + 1;
        e.acc_raw = edge_cnt + 1;
        exp_q.push_back(e);
        done = 1;
      end else if (n > 2000) begin
        chk("accept_timeout", 64'd1, 64'd0);
        done = 1;
      end
      n++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.dividend = 27'($urandom);
    bus.divisor  = 11'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    in_result = 0;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result",    64'({bus.quotient, bus.remainder, bus.div0, bus.ovf}), 64'd0);
    exp_q.delete();
    in_result = 0;
    #3 reset_n = 1'b1;
  endtask

  initial begin
    exp_t        e;
    logic [26:0] a;
    logic [10:0] b;
    int          n;
    int          mode;
    n_checks = 0; n_errors = 0; in_result = 0;
    edge_cnt = 0; ce_edge_cnt = 0; last_raw_lat = 0;
    reset_n = 1'b0; ce = 1'b1; ce_dir = 1'b1; rand_ce = 1'b0;
    ordy_dir = 1'b1; rand_ordy = 1'b0;
    bus.in_valid = 1'b0; bus.dividend = '0; bus.divisor = '0; bus.out_ready = 1'b1;

    // Result monitor: compares every presented result against the queue head
    fork
      forever begin
        @(negedge clk);
        if (reset_n && bus.out_valid) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out_valid", 64'd1, 64'd0);
          end else begin
            e = exp_q[0];
            if (!in_result) begin
              in_result    = 1;
              last_raw_lat = edge_cnt - e.acc_raw + 1;
              chk("latency", 64'(ce_edge_cnt - e.acc_ce + 1), 64'(e.lat));
            end
            chk("quotient",  64'(bus.quotient),  64'(e.q));
            chk("remainder", 64'(bus.remainder), 64'(e.r));
            chk("flags",     64'({bus.div0, bus.ovf}), 64'({e.d0, e.ov}));
            chk("in_ready_in_done", 64'(bus.in_ready), 64'd0);
            if (ce && bus.out_ready) begin
              void'(exp_q.pop_front());
              in_result = 0;
            end
          end
        end
      end
    join_none

    #12;
    chk("reset_in_ready",  64'(bus.in_ready),  64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_result",    64'({bus.quotient, bus.remainder, bus.div0, bus.ovf}), 64'd0);
    #11 reset_n = 1'b1;

    // Basic and boundary operations
    issue(27'd500000, 11'd500); drain();
    chk("lat_500000_500", 64'(last_raw_lat), 64'd18);
    issue(27'd134152191, 11'd2047);
    issue(27'd134150145, 11'd2047);
    issue(27'd1234, 11'd0); drain();
    chk("lat_div0", 64'(last_raw_lat), 64'd2);
    issue(27'h7FFFFFF, 11'd1);
    issue(27'd134217727, 11'd2047); drain();

    // Backpressure: result held 5 cycles while a second request waits
    ordy_dir = 1'b0;
    issue(27'd999, 11'd10);
    n = 0;
    while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    fork
      begin repeat (5) @(posedge clk); ordy_dir = 1'b1; end
      issue(27'd7, 11'd2);
    join
    drain();

    // Clock-enable stall of 4 cycles in the middle of the iteration
    issue(27'd500000, 11'd500);
    repeat (5) @(posedge clk);
    ce_dir = 1'b0;
    repeat (4) @(posedge clk);
    ce_dir = 1'b1;
    drain();
    chk("lat_ce_stall", 64'(last_raw_lat), 64'd22);

    // Reset mid-iteration, reset while a result is held, then recovery
    issue(27'd500000, 11'd500);
    repeat (6) @(posedge clk);
    reset_pulse();
    ordy_dir = 1'b0;
    issue(27'd100, 11'd3);
    n = 0;
    while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
    chk("pre_reset_out_valid", 64'(bus.out_valid), 64'd1);
    reset_pulse();
    ordy_dir = 1'b1;
    issue(27'd100, 11'd7); drain();

    // Randomized operations with enable and ready gaps
    rand_ce = 1'b1; rand_ordy = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        a = 27'($urandom); b = 11'd0;
      end else if (mode < 3) begin
        a = 27'($urandom); b = 11'($urandom);
      end else begin
        b = 11'($urandom_range(1, 2047));
        a = 27'(longint'($urandom_range(0, 65535)) * longint'(b) +
                longint'($urandom_range(0, int'(b) - 1)));
      end
      issue(a, b);
    end
    drain();
    rand_ce = 1'b0; rand_ordy = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_canny_accel_udiv_seq_27ns_11ns_16
`default_nettype wire
